imm_decode_stage: RTL and testbench

Registered immediate-decode stage that replaces the purely combinational immediate generator in the decode path. It accepts an instruction word, a one-hot format select and a tag, and produces the sign-extended immediate through a 2-entry valid/ready skid buffer. It is parametrised for XLEN, adds a CSR zero-extended immediate (Z) format, and reports malformed format selects with a per-beat error flag and a saturating counter instead of a simulation message. It sits between the fetch/decode register and the operand-select stage.

---
 rtl/imm_pkg.sv | 22 ++
 rtl/imm_extract.sv | 40 ++++
 rtl/imm_decode_stage.sv | 116 +++++++++++
 tb/tb_imm_decode_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the registered immediate-decode stage:
// one-hot instruction-format selects and the legal immediate widths.
package imm_pkg;

    localparam int TYPE_W = 7;

    typedef logic [TYPE_W-1:0] imm_type_t;

    // One-hot format selects, one bit per instruction format
    localparam imm_type_t TYPE_R = 7'b000_0001;
    localparam imm_type_t TYPE_I = 7'b000_0010;
    localparam imm_type_t TYPE_S = 7'b000_0100;
    localparam imm_type_t TYPE_B = 7'b000_1000;
    localparam imm_type_t TYPE_U = 7'b001_0000;
    localparam imm_type_t TYPE_J = 7'b010_0000;
    localparam imm_type_t TYPE_Z = 7'b100_0000;

    // Supported immediate widths
    localparam int XLEN_32 = 32;
    localparam int XLEN_64 = 64;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction. Every format is first assembled as a
// signed 32-bit value and then sign-extended to XLEN; the Z format carries
// a zero MSB so the same extension yields a zero-extended result.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]       inst,
    input  imm_type_t         sel,
    output logic [XLEN-1:0]   imm,
    output logic              err
);

    logic signed [31:0] imm32;

    // Select the bit-field layout for the requested format; anything that is
    // not exactly one format bit flags an error and yields a zero immediate
    always_comb begin
        imm32 = '0;
        err   = 1'b0;
        case (sel)
            TYPE_R: imm32 = '0;
            TYPE_I: imm32 = {{20{inst[31]}}, inst[31:20]};
            TYPE_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            TYPE_B: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                             inst[11:8], 1'b0};
            TYPE_U: imm32 = {inst[31:12], 12'b0};
            TYPE_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                             inst[30:21], 1'b0};
            TYPE_Z: imm32 = {27'b0, inst[19:15]};
            default: begin
                imm32 = '0;
                err   = 1'b1;
            end
        endcase
        imm = XLEN'(imm32);
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage. The immediate is extracted on the input
// side, then held in a two-entry valid/ready skid buffer (head + skid) so that
// in_ready depends only on registered occupancy, never on out_ready.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    input  logic [TYPE_W-1:0]    in_type,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_imm,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic [XLEN-1:0]  imm_p0;
    logic             err_p0;

    logic [1:0]       occ;
    logic [XLEN-1:0]  head_imm_p1;
    logic [TAG_W-1:0] head_tag_p1;
    logic             head_err_p1;
    logic [XLEN-1:0]  skid_imm_p1;
    logic [TAG_W-1:0] skid_tag_p1;
    logic             skid_err_p1;

    logic             accept;
    logic             emit;

    imm_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .inst (in_inst),
        .sel  (in_type),
        .imm  (imm_p0),
        .err  (err_p0)
    );

    // Ready comes from registered occupancy; held low while reset is asserted
    assign in_ready  = rst_n & (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign out_imm   = head_imm_p1;
    assign out_tag   = head_tag_p1;
    assign out_err   = head_err_p1;

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    // p0 -> p1: occupancy tracking and head/skid loading, order preserving
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ         <= 2'd0;
            head_imm_p1 <= '0;
            head_tag_p1 <= '0;
            head_err_p1 <= 1'b0;
            skid_imm_p1 <= '0;
            skid_tag_p1 <= '0;
            skid_err_p1 <= 1'b0;
        end else begin
            case (occ)
                2'd0: begin
                    if (accept) begin
                        head_imm_p1 <= imm_p0;
                        head_tag_p1 <= in_tag;
                        head_err_p1 <= err_p0;
                        occ         <= 2'd1;
                    end
                end
                2'd1: begin
                    if (accept && emit) begin
                        // Head leaves this cycle, so the new beat replaces it
                        head_imm_p1 <= imm_p0;
                        head_tag_p1 <= in_tag;
                        head_err_p1 <= err_p0;
                    end else if (accept) begin
                        skid_imm_p1 <= imm_p0;
                        skid_tag_p1 <= in_tag;
                        skid_err_p1 <= err_p0;
                        occ         <= 2'd2;
                    end else if (emit) begin
                        occ <= 2'd0;
                    end
                end
                default: begin
                    // Full: no accept is possible, only promote skid on emit
                    if (emit) begin
                        head_imm_p1 <= skid_imm_p1;
                        head_tag_p1 <= skid_tag_p1;
                        head_err_p1 <= skid_err_p1;
                        occ         <= 2'd1;
                    end
                end
            endcase
        end
    end

    // Count malformed format selects at accept time, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (accept && err_p0 && (err_count != {ERR_CNT_W{1'b1}})) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: three instances share one input stream
// (XLEN=32, XLEN=64, and a 2-bit error counter) and are checked against
// hand-computed immediates, tags and counters.
module tb_imm_decode_stage;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_inst;
    logic [6:0]  in_type;
    logic [7:0]  in_tag;

    logic        rdy_a, vld_a, err_a;
    logic [31:0] imm_a;
    logic [7:0]  tag_a, cnt_a;

    logic        rdy_b, vld_b, err_b;
    logic [63:0] imm_b;
    logic [7:0]  tag_b, cnt_b;

    logic        rdy_c, vld_c, err_c;
    logic [31:0] imm_c;
    logic [7:0]  tag_c;
    logic [1:0]  cnt_c;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    int sent;
    int got;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .TAG_W(8), .ERR_CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
        .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag),
        .out_valid(vld_a), .out_ready(out_ready), .out_imm(imm_a),
        .out_tag(tag_a), .out_err(err_a), .err_count(cnt_a)
    );

    imm_decode_stage #(.XLEN(64), .TAG_W(8), .ERR_CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
        .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag),
        .out_valid(vld_b), .out_ready(out_ready), .out_imm(imm_b),
        .out_tag(tag_b), .out_err(err_b), .err_count(cnt_b)
    );

    imm_decode_stage #(.XLEN(32), .TAG_W(8), .ERR_CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c),
        .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag),
        .out_valid(vld_c), .out_ready(out_ready), .out_imm(imm_c),
        .out_tag(tag_c), .out_err(err_c), .err_count(cnt_c)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst,
                         input logic [6:0] typ, input logic [7:0] tag);
        in_valid = v;
        in_inst  = inst;
        in_type  = typ;
        in_tag   = tag;
    endtask

    initial begin
        drive(1'b0, 32'h0, 7'h0, 8'h0);
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_in_ready",  64'(rdy_a), 64'd0);
        check("rst_out_valid", 64'(vld_a), 64'd0);
        check("rst_out_imm",   64'(imm_a), 64'd0);
        check("rst_out_tag",   64'(tag_a), 64'd0);
        check("rst_out_err",   64'(err_a), 64'd0);
        check("rst_err_count", 64'(cnt_a), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 64'(rdy_a), 64'd1);

        // Streaming, out_ready high, latency 1
        drive(1'b1, 32'hFFF00093, TYPE_I, 8'd1);
        tick();
        check("i_valid", 64'(vld_a), 64'd1);
        check("i_imm",   64'(imm_a), 64'hFFFFFFFF);
        check("i_tag",   64'(tag_a), 64'd1);
        check("i_err",   64'(err_a), 64'd0);
        drive(1'b1, 32'hFE000EE3, TYPE_B, 8'd2);
        tick();
        check("b_imm",   64'(imm_a), 64'hFFFFFFFC);
        check("b_tag",   64'(tag_a), 64'd2);
        drive(1'b1, 32'h800000EF, TYPE_J, 8'd3);
        tick();
        check("j_imm",   64'(imm_a), 64'hFFF00000);
        check("j_tag",   64'(tag_a), 64'd3);
        drive(1'b1, 32'hFE112E23, TYPE_S, 8'd4);
        tick();
        check("s_imm",   64'(imm_a), 64'hFFFFFFFC);
        drive(1'b1, 32'hFFFFFFFF, TYPE_R, 8'd5);
        tick();
        check("r_imm",   64'(imm_a), 64'd0);
        check("r_err",   64'(err_a), 64'd0);
        drive(1'b0, 32'h0, TYPE_R, 8'd0);
        tick();
        check("idle_valid", 64'(vld_a), 64'd0);

        // XLEN=64 extensions
        drive(1'b1, 32'h800002B7, TYPE_U, 8'd6);
        tick();
        check("u64_imm", imm_b, 64'hFFFFFFFF80000000);
        check("u32_imm", 64'(imm_a), 64'h80000000);
        drive(1'b1, 32'h000FD073, TYPE_Z, 8'd7);
        tick();
        check("z64_imm", imm_b, 64'h000000000000001F);
        check("z64_tag", 64'(tag_b), 64'd7);

        // Malformed format selects
        drive(1'b1, 32'hFFF00093, 7'b0000011, 8'd10);
        tick();
        check("e1_err", 64'(err_a), 64'd1);
        check("e1_imm", 64'(imm_a), 64'd0);
        check("e1_tag", 64'(tag_a), 64'd10);
        drive(1'b1, 32'hFFF00093, 7'b0000000, 8'd11);
        tick();
        check("e2_err", 64'(err_a), 64'd1);
        check("e2_imm", 64'(imm_a), 64'd0);
        check("e2_tag", 64'(tag_a), 64'd11);
        drive(1'b0, 32'h0, TYPE_R, 8'd0);
        tick();
        check("cnt_a_2", 64'(cnt_a), 64'd2);
        check("cnt_c_2", 64'(cnt_c), 64'd2);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h12345678, 7'h7F, 8'(12 + k));
            tick();
        end
        drive(1'b0, 32'h0, TYPE_R, 8'd0);
        tick();
        check("cnt_a_5",   64'(cnt_a), 64'd5);
        check("cnt_c_sat", 64'(cnt_c), 64'd3);

        // Backpressure: out_ready low for 4 cycles under continuous input
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            out_ready = (cyc >= 4);
            drive(sent < 6, 32'h00100093, TYPE_I, 8'(20 + sent));
            if (cyc == 1) check("bp_ready_1", 64'(rdy_a), 64'd1);
            if (cyc >= 1 && cyc <= 4) check("bp_hold_tag", 64'(tag_a), 64'd20);
            if (cyc >= 2 && cyc <= 4) check("bp_in_ready", 64'(rdy_a), 64'd0);
            if (vld_a && out_ready) begin
                if (exp_q.size() == 0) check("bp_extra", 64'(tag_a), 64'hFF);
                else check("bp_order", 64'(tag_a), 64'(exp_q.pop_front()));
                got++;
            end
            if (in_valid && rdy_a) begin
                exp_q.push_back(in_tag);
                sent++;
            end
            tick();
        end
        drive(1'b0, 32'h0, TYPE_R, 8'd0);
        check("bp_sent", 64'(sent), 64'd6);
        check("bp_got",  64'(got), 64'd6);
        check("bp_left", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset with occupancy 2
        out_ready = 1'b0;
        drive(1'b1, 32'h0, 7'h0, 8'd40);
        tick();
        drive(1'b1, 32'h0, 7'h0, 8'd41);
        tick();
        check("full_in_ready", 64'(rdy_a), 64'd0);
        check("full_cnt",      64'(cnt_a), 64'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid",   64'(vld_a), 64'd0);
        check("arst_cnt_a",   64'(cnt_a), 64'd0);
        check("arst_cnt_c",   64'(cnt_c), 64'd0);
        check("arst_in_rdy",  64'(rdy_a), 64'd0);
        drive(1'b0, 32'h0, TYPE_R, 8'd0);
        #2;
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(rdy_a), 64'd1);
        out_ready = 1'b1;
        drive(1'b1, 32'h00500093, TYPE_I, 8'd50);
        tick();
        check("post_rst_valid", 64'(vld_a), 64'd1);
        check("post_rst_tag",   64'(tag_a), 64'd50);
        check("post_rst_imm",   64'(imm_a), 64'd5);
        check("post_rst_err",   64'(err_a), 64'd0);
        drive(1'b0, 32'h0, TYPE_R, 8'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
